// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter granting whole CYC-held bus cycles on one RAM slave.
// Latency: one registered arbitration cycle from m_cyc_i to s_cyc_o, then combinational passthrough.
// Backpressure: slave ACK/ERR pass straight to the owner; a stalled slave is cut off by the watchdog ERR.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW = DW / 8;
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Watchdog fires after TIMEOUT stalled strobe cycles; the abort cycle is the one after that.
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   last_owner;
  logic [OW-1:0]   winner;
  logic [15:0]     wdog;

  logic [AW-1:0]   adr_a [NUM_MASTERS];
  logic [DW-1:0]   dat_a [NUM_MASTERS];
  logic [SW-1:0]   sel_a [NUM_MASTERS];
  logic [2:0]      cti_a [NUM_MASTERS];
  logic [1:0]      bte_a [NUM_MASTERS];

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OW-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the flat master buses into per-master lanes for clean owner muxing
  always_comb begin
    for (int n = 0; n < NUM_MASTERS; n++) begin
      adr_a[n] = m_adr_i[n*AW +: AW];
      dat_a[n] = m_dat_i[n*DW +: DW];
      sel_a[n] = m_sel_i[n*SW +: SW];
      cti_a[n] = m_cti_i[n*3 +: 3];
      bte_a[n] = m_bte_i[n*2 +: 2];
    end
  end

  // Round-robin pick: first requester scanning upward from last_owner+1, wrapping
  always_comb begin
    logic          found;
    logic [OW-1:0] kk;
    int            k;
    winner = last_owner;
    found  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      k = int'(last_owner) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      kk = OW'(k);
      if (!found && m_cyc_i[kk]) begin
        winner = kk;
        found  = 1'b1;
      end
    end
  end

  // Owner passthrough while OWNED; single-cycle ERR to the owner in ABORT; everything quiet otherwise
  always_comb begin
    m_dat_o = s_dat_i;
    m_ack_o = '0;
    m_err_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (state == OWNED) begin
      s_adr_o        = adr_a[owner];
      s_dat_o        = dat_a[owner];
      s_sel_o        = sel_a[owner];
      s_we_o         = m_we_i[owner];
      s_cyc_o        = m_cyc_i[owner];
      s_stb_o        = m_stb_i[owner] & m_cyc_i[owner];
      s_cti_o        = cti_a[owner];
      s_bte_o        = bte_a[owner];
      m_ack_o[owner] = s_ack_i;
      m_err_o[owner] = s_err_i;
    end else if (state == ABORT) begin
      m_err_o[owner] = 1'b1;
    end
  end

  // Ownership FSM with registered grant and stalled-strobe watchdog
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      grant_o    <= '0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (|m_cyc_i) begin
            state   <= OWNED;
            owner   <= winner;
            grant_o <= onehot(winner);
          end
        end
        OWNED: begin
          if (!m_cyc_i[owner]) begin
            state      <= IDLE;
            last_owner <= owner;
            grant_o    <= '0;
            wdog       <= '0;
          end else if (s_stb_o && !s_ack_i && !s_err_i) begin
            if (wdog == TO_M1) begin
              state   <= ABORT;
              grant_o <= '0;
              wdog    <= '0;
            end else begin
              wdog <= wdog + 16'd1;
            end
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          wdog <= '0;
          if (m_cyc_i[owner]) begin
            state   <= OWNED;
            grant_o <= onehot(owner);
          end else begin
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          wdog    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter with a grant/response scoreboard.
// Stimulus pushes expected grants and ACK/ERR responses; a negedge monitor pops and compares.
module tb_wb_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat;
  logic [N*DW/8-1:0] m_sel;
  logic [N-1:0]      m_we;
  logic [N-1:0]      m_cyc;
  logic [N-1:0]      m_stb;
  logic [N*3-1:0]    m_cti;
  logic [N*2-1:0]    m_bte;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o;
  logic [N-1:0]      m_err_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack;
  logic              s_err;
  logic [N-1:0]      grant;

  wb_ram_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [DW-1:0] dat;
  } resp_t;

  resp_t        rq[$];
  logic [N-1:0] gq[$];
  logic [N-1:0] prev_g;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb,
                       input logic [31:0] adr, input logic [2:0] cti);
    m_cyc[n]          = cyc;
    m_stb[n]          = stb;
    m_adr[n*AW +: AW] = adr;
    m_cti[n*3 +: 3]   = cti;
  endtask

  task automatic push_resp(input logic [N-1:0] a, input logic [N-1:0] e, input logic [DW-1:0] d);
    resp_t r;
    r.ack = a;
    r.err = e;
    r.dat = d;
    rq.push_back(r);
  endtask

  task automatic wait_grant();
    int n = 0;
    tick();
    while (grant == '0 && n < 10) begin
      tick();
      n++;
    end
    if (grant == '0) chk("wait_grant_timeout", 64'(grant), 64'd1);
  endtask

  task automatic do_reset();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  // Monitor: compare every new grant and every ACK/ERR pulse against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_g = '0;
    end else begin
      if (grant !== prev_g && grant != '0) begin
        checks++;
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL grant_unexpected: got %b expected none", grant);
        end else begin
          logic [N-1:0] eg;
          eg = gq.pop_front();
          if (grant !== eg) begin
            fails++;
            $display("FAIL grant_order: got %b expected %b", grant, eg);
          end
        end
      end
      prev_g = grant;
      if ((m_ack_o | m_err_o) != '0) begin
        checks++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL resp_unexpected: got ack %b err %b expected none", m_ack_o, m_err_o);
        end else begin
          resp_t er;
          er = rq.pop_front();
          if (m_ack_o !== er.ack || m_err_o !== er.err || m_dat_o !== er.dat) begin
            fails++;
            $display("FAIL resp: got ack %b err %b dat %h expected ack %b err %b dat %h",
                     m_ack_o, m_err_o, m_dat_o, er.ack, er.err, er.dat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [N-1:0] ORDER [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst   = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '1; m_we = '0;
    m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
    s_dat = 32'h1234_5678; s_ack = 1'b0; s_err = 1'b0;
    #1;
    // Reset state
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_ack_err", 64'({m_ack_o, m_err_o}), 64'd0);
    chk("rst_m_dat", 64'(m_dat_o), 64'h1234_5678);
    tick();
    tick();
    rst = 1'b0;

    // Test 1: single read from m0, slave acks two cycles after grant
    set_m(0, 1'b1, 1'b1, 32'h100, 3'b000);
    gq.push_back(3'b001);
    tick();
    chk("t1_s_cyc", 64'(s_cyc_o), 64'd1);
    chk("t1_s_adr", 64'(s_adr_o), 64'h100);
    tick();
    tick();
    s_ack = 1'b1; s_dat = 32'hDEAD_0001;
    push_resp(3'b001, 3'b000, 32'hDEAD_0001);
    tick();
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // Test 2: all request continuously, one ack each, round-robin 0,1,2,0
    do_reset();
    for (int i = 0; i < 4; i++) gq.push_back(ORDER[i]);
    m_cyc = 3'b111;
    m_stb = 3'b111;
    for (int it = 0; it < 4; it++) begin
      wait_grant();
      s_ack = 1'b1; s_dat = 32'hA000_0000 + 32'(it);
      push_resp(ORDER[it], 3'b000, 32'hA000_0000 + 32'(it));
      tick();
      s_ack = 1'b0;
      if (it == 3) begin
        m_cyc = '0;
        m_stb = '0;
      end else begin
        m_cyc = m_cyc & ~ORDER[it];
      end
      tick();
      chk("t2_dead_idle", 64'(grant), 64'd0);
      if (it != 3) m_cyc = 3'b111;
    end
    tick();

    // Test 3: m1 4-beat burst with m0 waiting; m0 granted only after m1 drops cyc
    set_m(1, 1'b1, 1'b1, 32'h200, 3'b010);
    gq.push_back(3'b010);
    tick();
    set_m(0, 1'b1, 1'b1, 32'h180, 3'b000);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 1'b1, 32'h200 + 32'(4*b), (b == 3) ? 3'b111 : 3'b010);
      s_ack = 1'b1; s_dat = 32'hB000_0000 + 32'(b);
      push_resp(3'b010, 3'b000, 32'hB000_0000 + 32'(b));
      #1;
      chk("t3_s_cti", 64'(s_cti_o), (b == 3) ? 64'd7 : 64'd2);
      chk("t3_s_adr", 64'(s_adr_o), 64'h200 + 64'(4*b));
      tick();
    end
    s_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
    gq.push_back(3'b001);
    tick();
    chk("t3_dead_idle", 64'(grant), 64'd0);
    tick();
    s_ack = 1'b1; s_dat = 32'hC000_0000;
    push_resp(3'b001, 3'b000, 32'hC000_0000);
    tick();
    s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // Test 4a: m2 read never acked; ERR on the 9th strobe cycle
    s_dat = 32'hEEEE_0000;
    set_m(2, 1'b1, 1'b1, 32'h300, 3'b000);
    gq.push_back(3'b100);
    for (int c = 1; c <= 8; c++) tick();
    chk("t4_stb_c8", 64'(s_stb_o), 64'd1);
    tick();
    push_resp(3'b000, 3'b100, 32'hEEEE_0000);
    chk("t4_abort_stb", 64'(s_stb_o), 64'd0);
    chk("t4_abort_cyc", 64'(s_cyc_o), 64'd0);
    set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // Test 4b: ack lands on cycle 8 instead; passes, no ERR
    set_m(2, 1'b1, 1'b1, 32'h304, 3'b000);
    gq.push_back(3'b100);
    for (int c = 1; c <= 7; c++) tick();
    tick();
    s_ack = 1'b1; s_dat = 32'hEEEE_0008;
    push_resp(3'b100, 3'b000, 32'hEEEE_0008);
    tick();
    s_ack = 1'b0;
    chk("t4b_no_err", 64'(m_err_o), 64'd0);
    set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
    tick();
    tick();

    // Test 5: async reset mid-burst of m2, then m0 wins first
    set_m(2, 1'b1, 1'b1, 32'h400, 3'b010);
    gq.push_back(3'b100);
    tick();
    s_ack = 1'b1; s_dat = 32'hD000_0000;
    push_resp(3'b100, 3'b000, 32'hD000_0000);
    tick();
    s_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_cyc", 64'(s_cyc_o), 64'd0);
    chk("t5_async_grant", 64'(grant), 64'd0);
    m_cyc = 3'b111;
    m_stb = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    gq.push_back(3'b001);
    tick();
    s_ack = 1'b1; s_dat = 32'hD000_0001;
    push_resp(3'b001, 3'b000, 32'hD000_0001);
    tick();
    s_ack = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    tick();
    tick();

    // Test 6: spurious slave ACK/ERR while idle
    s_ack = 1'b1;
    s_err = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t6_idle_ack", 64'(m_ack_o), 64'd0);
      chk("t6_idle_err", 64'(m_err_o), 64'd0);
      tick();
    end
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();

    chk("end_resp_queue", 64'(rq.size()), 64'd0);
    chk("end_grant_queue", 64'(gq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
